mem_responder: RTL and testbench

//  Responder end of the request-unit/cache handshake: accepts imemREN, dmemREN and dmemWEN

---
 rtl/mem_responder_if.sv | 31 +++
 rtl/mem_responder.sv | 134 +++++++++++++
 tb/tb_mem_responder.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Handshake bundle between the request unit/caches, the memory responder and the RAM model.
interface mem_responder_if #(
  parameter int unsigned WORD_W = 32
);
  logic              imemREN;
  logic [WORD_W-1:0] imemaddr;
  logic              dmemREN;
  logic              dmemWEN;
  logic [WORD_W-1:0] dmemaddr;
  logic [WORD_W-1:0] dmemstore;
  logic              ihit;
  logic              dhit;
  logic [WORD_W-1:0] imemload;
  logic [WORD_W-1:0] dmemload;
  logic              ramREN;
  logic              ramWEN;
  logic [WORD_W-1:0] ramaddr;
  logic [WORD_W-1:0] ramstore;
  logic [WORD_W-1:0] ramload;
  logic              req_err;

  modport slave (
    input  imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, ramload,
    output ihit, dhit, imemload, dmemload, ramREN, ramWEN, ramaddr, ramstore, req_err
  );

  modport master (
    output imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, ramload,
    input  ihit, dhit, imemload, dmemload, ramREN, ramWEN, ramaddr, ramstore, req_err
  );
endinterface

// File: rtl/mem_responder.sv
// Arbitrates instruction/data requests onto one fixed-latency RAM port and returns hit pulses.
// Define RR_ARB_EN for round-robin arbitration; default is fixed data priority.
module mem_responder #(
  parameter int unsigned LAT    = 2,
  parameter int unsigned WORD_W = 32
) (
  input  logic            CLK,
  input  logic            nRST,
  mem_responder_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2
  } state_t;

  if (LAT > 15) begin : g_lat_check
    $error("mem_responder: LAT must be in 0..15");
  end

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [WORD_W-1:0] ramaddr_q, ramaddr_d;
  logic [WORD_W-1:0] ramstore_q, ramstore_d;
  logic              req_err_q, req_err_d;
  logic              last_d_q, last_d_d;
  logic              dreq_s, pick_d_s, ihit_s, dhit_s;

  assign dreq_s = bus.dmemREN | bus.dmemWEN;

  // Grant selection when the responder is idle.
  always_comb begin
    pick_d_s = dreq_s;
`ifdef RR_ARB_EN
    if (dreq_s && bus.imemREN) begin
      pick_d_s = ~last_d_q;
    end else begin
      pick_d_s = dreq_s;
    end
`endif
  end

  // Next-state, latch and hit logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    ramaddr_d  = ramaddr_q;
    ramstore_d = ramstore_q;
    last_d_d   = last_d_q;
    req_err_d  = req_err_q | (bus.dmemREN & bus.dmemWEN);
    ihit_s     = 1'b0;
    dhit_s     = 1'b0;
    case (state_q)
      IDLE: begin
        if (dreq_s || bus.imemREN) begin
          cnt_d    = 4'(LAT);
          last_d_d = pick_d_s;
          if (pick_d_s) begin
            state_d    = DACC;
            wr_d       = bus.dmemWEN;
            ramaddr_d  = bus.dmemaddr;
            ramstore_d = bus.dmemstore;
          end else begin
            state_d   = IACC;
            wr_d      = 1'b0;
            ramaddr_d = bus.imemaddr;
          end
        end else begin
          state_d = IDLE;
        end
      end
      IACC: begin
        // A dropped request aborts the access without a hit.
        if (!bus.imemREN) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          ihit_s  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DACC: begin
        if (!dreq_s) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          dhit_s  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latched-request registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      wr_q       <= 1'b0;
      ramaddr_q  <= {WORD_W{1'b0}};
      ramstore_q <= {WORD_W{1'b0}};
      req_err_q  <= 1'b0;
      last_d_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      ramaddr_q  <= ramaddr_d;
      ramstore_q <= ramstore_d;
      req_err_q  <= req_err_d;
      last_d_q   <= last_d_d;
    end
  end

  // Loads are a same-cycle pass-through of the RAM data on the completing cycle.
  assign bus.ihit     = ihit_s;
  assign bus.dhit     = dhit_s;
  assign bus.imemload = ihit_s ? bus.ramload : {WORD_W{1'b0}};
  assign bus.dmemload = (dhit_s && !wr_q) ? bus.ramload : {WORD_W{1'b0}};
  assign bus.ramREN   = (state_q == IACC) || ((state_q == DACC) && !wr_q);
  assign bus.ramWEN   = (state_q == DACC) && wr_q;
  assign bus.ramaddr  = ramaddr_q;
  assign bus.ramstore = ramstore_q;
  assign bus.req_err  = req_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (LAT=2 main instance, LAT=0 side instance).
module tb_mem_responder;

  localparam logic [31:0] LOAD = 32'h8C22_0004;

  logic CLK;
  logic nRST;
  int   n_total = 0;
  int   n_bad   = 0;

  mem_responder_if #(.WORD_W(32)) bus ();
  mem_responder_if #(.WORD_W(32)) bus0 ();

  mem_responder #(.LAT(2), .WORD_W(32)) dut (.CLK(CLK), .nRST(nRST), .bus(bus.slave));
  mem_responder #(.LAT(0), .WORD_W(32)) dut0 (.CLK(CLK), .nRST(nRST), .bus(bus0.slave));

  assign bus0.imemREN   = bus.imemREN;
  assign bus0.imemaddr  = bus.imemaddr;
  assign bus0.dmemREN   = bus.dmemREN;
  assign bus0.dmemWEN   = bus.dmemWEN;
  assign bus0.dmemaddr  = bus.dmemaddr;
  assign bus0.dmemstore = bus.dmemstore;
  assign bus0.ramload   = bus.ramload;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Waits for the sampling edge of the current cycle and checks the main outputs.
  task automatic cyc(input string t, input int c, input logic er, input logic ew,
                     input logic eih, input logic edh, input logic [31:0] eil,
                     input logic [31:0] edl);
    @(negedge CLK);
    check_eq($sformatf("%s.c%0d.ramREN", t, c), {31'd0, bus.ramREN}, {31'd0, er});
    check_eq($sformatf("%s.c%0d.ramWEN", t, c), {31'd0, bus.ramWEN}, {31'd0, ew});
    check_eq($sformatf("%s.c%0d.ihit", t, c), {31'd0, bus.ihit}, {31'd0, eih});
    check_eq($sformatf("%s.c%0d.dhit", t, c), {31'd0, bus.dhit}, {31'd0, edh});
    check_eq($sformatf("%s.c%0d.imemload", t, c), bus.imemload, eil);
    check_eq($sformatf("%s.c%0d.dmemload", t, c), bus.dmemload, edl);
  endtask

  task automatic adv();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic i_first;
    nRST          = 1'b0;
    bus.imemREN   = 1'b0;
    bus.imemaddr  = 32'h0;
    bus.dmemREN   = 1'b0;
    bus.dmemWEN   = 1'b0;
    bus.dmemaddr  = 32'h0;
    bus.dmemstore = 32'h0;
    bus.ramload   = LOAD;

    cyc("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check_eq("reset.ramaddr", bus.ramaddr, 32'h0);
    check_eq("reset.ramstore", bus.ramstore, 32'h0);
    check_eq("reset.req_err", {31'd0, bus.req_err}, 32'd0);
    adv();
    nRST = 1'b1;

    // Instruction fetch, LAT=2: strobe cycles 1-3, hit in cycle 3.
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h40;
    for (int c = 0; c <= 4; c++) begin
      if (c == 4) bus.imemREN = 1'b0;
      cyc("ifetch", c, (c >= 1 && c <= 3), 1'b0, (c == 3), 1'b0,
          (c == 3) ? LOAD : 32'h0, 32'h0);
      if (c == 1) check_eq("ifetch.ramaddr", bus.ramaddr, 32'h40);
      if (c <= 2) check_eq($sformatf("lat0.c%0d.ihit", c), {31'd0, bus0.ihit},
                           {31'd0, (c == 1)});
      adv();
    end

    // Data write.
    bus.dmemWEN   = 1'b1;
    bus.dmemaddr  = 32'h100;
    bus.dmemstore = 32'hDEAD_BEEF;
    for (int c = 0; c <= 4; c++) begin
      if (c == 4) bus.dmemWEN = 1'b0;
      cyc("dwrite", c, 1'b0, (c >= 1 && c <= 3), 1'b0, (c == 3), 32'h0, 32'h0);
      if (c == 1) check_eq("dwrite.ramaddr", bus.ramaddr, 32'h100);
      if (c == 1) check_eq("dwrite.ramstore", bus.ramstore, 32'hDEAD_BEEF);
      adv();
    end

    // Both requests together; the last grant was data.
`ifdef RR_ARB_EN
    i_first = 1'b1;
`else
    i_first = 1'b0;
`endif
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h80;
    bus.dmemREN  = 1'b1;
    bus.dmemaddr = 32'h140;
    for (int c = 0; c <= 8; c++) begin
      logic first_hit, second_hit;
      if (c == 4) begin
        if (i_first) bus.imemREN = 1'b0;
        else         bus.dmemREN = 1'b0;
      end
      if (c == 8) begin
        bus.imemREN = 1'b0;
        bus.dmemREN = 1'b0;
      end
      first_hit  = (c == 3);
      second_hit = (c == 7);
      cyc("both", c, (c >= 1 && c <= 3) || (c >= 5 && c <= 7), 1'b0,
          i_first ? first_hit : second_hit, i_first ? second_hit : first_hit,
          (i_first ? first_hit : second_hit) ? LOAD : 32'h0,
          (i_first ? second_hit : first_hit) ? LOAD : 32'h0);
      if (c == 2) check_eq("both.addr1", bus.ramaddr, i_first ? 32'h80 : 32'h140);
      if (c == 6) check_eq("both.addr2", bus.ramaddr, i_first ? 32'h140 : 32'h80);
      adv();
    end

    // Abort: data read dropped in cycle 2.
    bus.dmemREN  = 1'b1;
    bus.dmemaddr = 32'h180;
    for (int c = 0; c <= 4; c++) begin
      if (c == 2) bus.dmemREN = 1'b0;
      cyc("abort", c, (c == 1 || c == 2), 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      adv();
    end

    // Read and write together: performed as a write, sticky error.
    bus.dmemREN   = 1'b1;
    bus.dmemWEN   = 1'b1;
    bus.dmemaddr  = 32'h200;
    bus.dmemstore = 32'h1234_5678;
    for (int c = 0; c <= 6; c++) begin
      if (c == 4) begin
        bus.dmemREN = 1'b0;
        bus.dmemWEN = 1'b0;
      end
      cyc("rw", c, 1'b0, (c >= 1 && c <= 3), 1'b0, (c == 3), 32'h0, 32'h0);
      check_eq($sformatf("rw.c%0d.req_err", c), {31'd0, bus.req_err}, {31'd0, (c >= 1)});
      adv();
    end

    // Reset pulsed in cycle 2 of a data read.
    bus.dmemREN  = 1'b1;
    bus.dmemaddr = 32'h300;
    cyc("rst", 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    adv();
    cyc("rst", 1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    adv();
    nRST        = 1'b0;
    bus.dmemREN = 1'b0;
    cyc("rst", 2, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check_eq("rst.ramaddr", bus.ramaddr, 32'h0);
    check_eq("rst.ramstore", bus.ramstore, 32'h0);
    check_eq("rst.req_err", {31'd0, bus.req_err}, 32'd0);
    adv();
    nRST = 1'b1;
    for (int c = 3; c <= 4; c++) begin
      cyc("rst", c, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      adv();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
